// File: rtl/id_stage.sv
// MIPS instruction-decode stage: 32x32 register file with write-through bypass,
// immediate extension, and the ID/EX pipeline register with stall and flush.
module id_stage (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] Ins_in,
   input  logic [31:0] nextPC_in,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        Wen,
   input  logic [4:0]  Waddr,
   input  logic [31:0] Wdata,
   output logic [31:0] Ins,
   output logic [31:0] nextPC,
   output logic [31:0] Rdata1,
   output logic [31:0] Rdata2,
   output logic [31:0] Ed32
);

   // Handshake: none. Stall and Flush are level-sampled on every rising CLK
   // edge; Flush wins over Stall, and write-back is never blocked by either.

   localparam logic [31:0] INS_NOP = 32'h0000_0000;

   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_XORI = 6'h0E;
   localparam logic [5:0] OP_LUI  = 6'h0F;

   logic [31:0] rf [32];

   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [15:0] imm;

   logic        wr_en;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic [31:0] ext_imm;

   logic [4:0]  held_rs;
   logic [4:0]  held_rt;
   logic        refresh1;
   logic        refresh2;

   assign opcode = Ins_in[31:26];
   assign rs     = Ins_in[25:21];
   assign rt     = Ins_in[20:16];
   assign imm    = Ins_in[15:0];

   // r0 is hardwired to zero, so a write addressed to it is dropped everywhere:
   // array, bypass and stall refresh all key off this one qualified enable.
   assign wr_en = Wen && (Waddr != 5'd0);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < 32; i++) begin
            rf[i] <= '0;
         end
      end else if (wr_en) begin
         rf[Waddr] <= Wdata;
      end
   end

   always_comb begin
      rd1 = '0;
      if (rs != 5'd0) begin
         rd1 = (wr_en && (Waddr == rs)) ? Wdata : rf[rs];
      end
   end

   always_comb begin
      rd2 = '0;
      if (rt != 5'd0) begin
         rd2 = (wr_en && (Waddr == rt)) ? Wdata : rf[rt];
      end
   end

   always_comb begin
      ext_imm = {{16{imm[15]}}, imm};
      case (opcode)
         OP_ANDI, OP_ORI, OP_XORI: ext_imm = {16'h0000, imm};
         OP_LUI:                   ext_imm = {imm, 16'h0000};
         default:                  ext_imm = {{16{imm[15]}}, imm};
      endcase
   end

   // During a stall the held operands track write-back to their own source
   // registers so they are not stale when the stall releases.
   assign held_rs  = Ins[25:21];
   assign held_rt  = Ins[20:16];
   assign refresh1 = wr_en && (Waddr == held_rs);
   assign refresh2 = wr_en && (Waddr == held_rt);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         Ins    <= INS_NOP;
         nextPC <= '0;
         Rdata1 <= '0;
         Rdata2 <= '0;
         Ed32   <= '0;
      end else if (Flush) begin
         Ins    <= INS_NOP;
         nextPC <= '0;
         Rdata1 <= '0;
         Rdata2 <= '0;
         Ed32   <= '0;
      end else if (Stall) begin
         if (refresh1) begin
            Rdata1 <= Wdata;
         end
         if (refresh2) begin
            Rdata2 <= Wdata;
         end
      end else begin
         Ins    <= Ins_in;
         nextPC <= nextPC_in;
         Rdata1 <= rd1;
         Rdata2 <= rd2;
         Ed32   <= ext_imm;
      end
   end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the MIPS pipeline: it owns the 32×32 general-purpose register file and produces the operand bundle consumed by the EX stage (Ins, nextPC, Rdata1, Rdata2, Ed32). It reads operands for the instruction delivered by IF, extends the immediate, and registers everything into the ID/EX pipeline register. It also accepts the write-back port from WB and supports stall and flush control from the hazard unit.

## Interface
- INS_NOP, 32'h0000_0000, instruction word loaded into Ins on reset and flush (SLL r0,r0,0).
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-low reset.
- Ins_in  in  32  instruction from IF.
- nextPC_in  in  32  PC+4 from IF.
- Stall  in  1  hold the ID/EX register.
- Flush  in  1  load a bubble into the ID/EX register.
- Wen  in  1  write-back enable.
- Waddr  in  5  write-back register number.
- Wdata  in  32  write-back data.
- Ins  out  32  registered instruction to EX.
- nextPC  out  32  registered PC+4 to EX.
- Rdata1  out  32  registered rs operand.
- Rdata2  out  32  registered rt operand.
- Ed32  out  32  registered extended immediate.

## Operation
- Register file: 32 entries × 32 bits. All entries clear asynchronously while RST=0.
- Register-file write: on the rising CLK edge when Wen=1 and Waddr≠0. r0 always reads 0, and writes to r0 are ignored.
- Register-file writes happen regardless of Stall and Flush.
- Read addresses: rs=Ins_in[25:21], rt=Ins_in[20:16].
- Read result: 0 when the address is 0. Otherwise, when Wen=1 and Waddr equals the address, the result is Wdata (write-through bypass). Otherwise it is the stored entry.
- Immediate extension, with imm=Ins_in[15:0] and opcode=Ins_in[31:26]:
  - opcode 0x0C/0x0D/0x0E (ANDI/ORI/XORI): zero-extend to {16'h0, imm}.
  - opcode 0x0F (LUI): {imm, 16'h0}.
  - All other opcodes, including R-type: sign-extend to {{16{imm[15]}}, imm}.
- ID/EX register update on each rising edge, in priority order:
  - Flush=1: Ins←INS_NOP; nextPC, Rdata1, Rdata2 and Ed32 ← 0.
  - Stall=1: Ins, nextPC and Ed32 hold. Rdata1 and Rdata2 also hold, except as follows:
    - When Wen=1, Waddr≠0 and Waddr equals the held Ins[25:21], Rdata1←Wdata.
    - Likewise Rdata2←Wdata when Waddr equals the held Ins[20:16].
    - This keeps held operands coherent with writes that retire during the stall.
  - Otherwise: load Ins_in, nextPC_in, the two read results and the extended immediate.
- Flush overrides Stall when both are asserted.

## Timing
- Reset (RST=0, asynchronous): Ins=INS_NOP; nextPC, Rdata1, Rdata2 and Ed32 = 0; all registers = 0.
- The first capture happens on the first rising edge after RST deasserts.
- Latency: inputs sampled at edge N appear on the outputs after edge N, i.e. 1 cycle.
- Write-back visibility:
  - A write at edge N is visible to a read in the same cycle through the bypass, so it is captured at edge N.
  - Later reads see it from the array.
- No handshake; Stall and Flush are level-sampled each edge.
- Simultaneous Wen to the same register as both rs and rt: both operands take Wdata.
- Waddr=0 with Wen=1: no array change, no bypass, no stall-refresh.
- Stall held for K cycles: the outputs are unchanged except for the refresh above. Release loads the current Ins_in.
- Ports are single-cycle combinational into flops; there are no multicycle paths.

## Test plan
- Reset: drive RST=0 mid-run.
  - Required: outputs go to Ins=0 and zeros immediately, without a clock.
  - Required: after release, reading any register yields 0.
- Write then read with bypass:
  - Wen=1, Waddr=5, Wdata=32'h1234_5678 in the same cycle as Ins_in=ADD rs=5, rt=5 -> next cycle Rdata1=Rdata2=32'h1234_5678.
  - A later ADD rs=5 reads the same value from the array.
- r0: Wen=1, Waddr=0, Wdata=32'hFFFF_FFFF, then Ins_in with rs=0 -> Rdata1=0.
- Extension: imm=16'h8001 with the following opcodes:
  - ADDI (0x08) -> Ed32=32'hFFFF_8001.
  - ORI (0x0D) -> Ed32=32'h0000_8001.
  - LUI (0x0F) -> Ed32=32'h8001_0000.
- Stall refresh:
  - Capture ADD rs=3 with r3=7, then hold Stall=1 for 3 cycles while Wen writes r3=9 in cycle 2.
  - Required: Rdata1=7, then 9; Ins and Ed32 unchanged.
  - Required: on release, the next Ins_in is loaded.
- Flush priority: Stall=1 and Flush=1 with valid Ins_in -> Ins=INS_NOP, nextPC=Rdata1=Rdata2=Ed32=0, and a concurrent write-back still lands in the array.
